mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
// - Shares the single MEM port between two requesters: the CPU datapath (FSM-sequenced address/data buses) and a
//   program loader/debug port (switch/button driven). Sits between both requesters and the MEM instance.
// - Req/gnt handshake, burst lock with a starvation limit, read-data return pipeline tagged to the issuing requester.
// PARAMETERS
// - ADDR_WIDTH   16  address width, matches MEM
// - DATA_WIDTH   8   data width, matches MEM
// - MEM_LATENCY  1   cycles from mem_en (read) to valid mem_rdata; range 1..4
// - MAX_BURST    4   max consecutive locked grants to one requester while the other waits; range 1..15
// PORTS
// - clk        in   1           clock, all state on rising edge
// - rst        in   1           asynchronous, active-high reset
// - cpu_req    in   1           CPU request; held with cmd fields stable until cpu_gnt
// - cpu_we     in   1           1 = write, 0 = read
// - cpu_lock   in   1           request to keep ownership after this transfer
// - cpu_addr   in   ADDR_WIDTH  CPU address
// - cpu_wdata  in   DATA_WIDTH  CPU write data
// - cpu_gnt    out  1           transfer accepted this cycle
// - cpu_rvalid out  1           cpu_rdata valid (one pulse per accepted read)
// - cpu_rdata  out  DATA_WIDTH  read data to CPU
// - ldr_req/ldr_we/ldr_lock/ldr_addr/ldr_wdata/ldr_gnt/ldr_rvalid/ldr_rdata  same as cpu_* for the loader port
// - mem_en     out  1           MEM enable
// - mem_we     out  1           MEM mode, 1 = write
// - mem_addr   out  ADDR_WIDTH  MEM address
// - mem_wdata  out  DATA_WIDTH  MEM write data
// - mem_rdata  in   DATA_WIDTH  MEM read data
// - busy       out  1           ownership held (state OWN) or a read in flight
// BEHAVIOUR
// - Reset: state IDLE, owner=CPU, burst_cnt=0, rd pipe empty; every output 0 (mem_* buses 0).
// - States: IDLE -> OWN on any req (winner latched at edge). OWN: owner's fields drive mem_*, mem_en=1,
//   owner gnt=1 combinationally in the same cycle. OWN exit at edge: stay if owner req&&lock and
//   (other !req or burst_cnt<MAX_BURST-1); else re-arbitrate (other if req, else owner if req, else IDLE).
// - Latency: request rising in IDLE -> gnt 1 cycle later; back-to-back locked grants, 1 transfer/cycle.
// - burst_cnt increments per consecutive grant to the same owner, clears on owner change or IDLE; saturates.
// - Owner stops req while in OWN: no gnt/mem_en that cycle, state -> IDLE or other requester next edge.
// - Read return: shift pipe depth MEM_LATENCY carries {valid, owner}; rvalid pulses exactly MEM_LATENCY cycles
//   after gnt, rdata = mem_rdata that cycle, only to tagged requester; other rdata holds 0. Writes return nothing.
// - Simultaneous req from IDLE: fixed priority loader > CPU (unless macro, below).
// - lock on a final request with no successor: ownership released next edge; lock is not sticky.
// - rst mid-burst/mid-read: immediate return to reset values; in-flight rvalid dropped, never delivered.
// CONFIGURATION
// - ARB_ROUND_ROBIN_EN defined: simultaneous-request ties go to the requester not granted most recently
//   (last_owner flop, reset CPU, so first tie -> loader). Undefined: fixed loader > CPU, no last_owner flop.
// - MAX_BURST starvation limit applies in both builds.
// STRUCTURE
// - Shared package: arb_owner_t enum {ARB_OWNER_CPU=1'b0, ARB_OWNER_LDR=1'b1}, arb_state_t {ARB_IDLE, ARB_OWN};
//   alongside existing reg_op_t/alu_op_t typedefs.
// - One sub-module: mem_arb_rd_pipe (parameterised MEM_LATENCY shift register of {valid, owner}).
// - Top: state/owner/burst_cnt flops, winner logic, mem_* output mux.
// TESTING
// - Reset mid-read: rst during rvalid-pending cycle -> no rvalid later, all outputs 0 while rst high.
// - Single CPU read addr 0x1234: cpu_req 1 cycle after IDLE -> cpu_gnt=1, mem_addr=0x1234, mem_we=0;
//   MEM returns 0xA5 -> cpu_rvalid=1, cpu_rdata=0xA5 exactly MEM_LATENCY cycles later.
// - Tie from IDLE, fixed build: both req -> ldr_gnt first; CPU granted next cycle after loader drops req.
// - Tie, ARB_ROUND_ROBIN_EN build: alternate ties -> grants LDR, CPU, LDR, CPU.
// - Starvation: loader holds req+lock writing 0x00..0x07, CPU req held -> exactly 4 ldr_gnt, then cpu_gnt,
//   then loader resumes; mem_wdata matches each granted port.
// - Interleaved reads, MEM_LATENCY=2: ldr read 0x0010 then cpu read 0x0020 back-to-back -> ldr_rvalid then
//   cpu_rvalid on consecutive cycles, each with its own data, never cross-delivered.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared datapath typedefs plus the MEM arbiter owner/state encodings and read-return tag.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    REG_OP_NONE  = 2'd0,
    REG_OP_LOAD  = 2'd1,
    REG_OP_STORE = 2'd2
  } reg_op_t;

  typedef enum logic [2:0] {
    ALU_OP_ADD  = 3'd0,
    ALU_OP_SUB  = 3'd1,
    ALU_OP_AND  = 3'd2,
    ALU_OP_OR   = 3'd3,
    ALU_OP_XOR  = 3'd4,
    ALU_OP_PASS = 3'd5
  } alu_op_t;

  typedef enum logic {
    ARB_OWNER_CPU = 1'b0,
    ARB_OWNER_LDR = 1'b1
  } arb_owner_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic       valid;
    arb_owner_t owner;
  } arb_rd_tag_t;

  function automatic arb_owner_t arb_other(input arb_owner_t owner);
    return (owner == ARB_OWNER_CPU) ? ARB_OWNER_LDR : ARB_OWNER_CPU;
  endfunction

endpackage

// File: rtl/mem_arb_rd_pipe.sv
// Read-return tag pipe: carries {valid, owner} of each accepted read for MEM_LATENCY cycles so the
// returning mem_rdata can be steered to the requester that issued it.
module mem_arb_rd_pipe
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  arb_rd_tag_t tag_i,
  output arb_rd_tag_t tag_o,
  output logic        inflight_o
);

  arb_rd_tag_t [MEM_LATENCY-1:0] pipe_q;

  // NOTE: sequential state uses non-blocking assignments; the pipe is reset as a whole because a stale
  // valid bit surviving reset would deliver a phantom read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < int'(MEM_LATENCY); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tag_o = pipe_q[MEM_LATENCY-1];

  // NOTE: every combinational output gets a default before any conditional update, so no latch is inferred.
  always_comb begin
    inflight_o = 1'b0;
    for (int i = 0; i < int'(MEM_LATENCY); i++) begin
      inflight_o = inflight_o | pipe_q[i].valid;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the MEM port between the CPU and the loader/debug port: req/gnt, locked bursts bounded by
// MAX_BURST, tagged read return. Define ARB_ROUND_ROBIN_EN for round-robin tie-breaks from IDLE.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned MAX_BURST   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic                  cpu_lock,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  ldr_req,
  input  logic                  ldr_we,
  input  logic                  ldr_lock,
  input  logic [ADDR_WIDTH-1:0] ldr_addr,
  input  logic [DATA_WIDTH-1:0] ldr_wdata,
  output logic                  ldr_gnt,
  output logic                  ldr_rvalid,
  output logic [DATA_WIDTH-1:0] ldr_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_t            state_q, state_d;
  arb_owner_t            owner_q, owner_d;
  arb_owner_t            idle_winner, other;
  logic [CNT_W-1:0]      burst_cnt_q, burst_cnt_d;
  logic                  own_req, own_lock, own_we, oth_req, grant, rd_inflight;
  logic [ADDR_WIDTH-1:0] own_addr;
  logic [DATA_WIDTH-1:0] own_wdata;
  arb_rd_tag_t           rd_tag_in, rd_tag_out;

  assign other     = arb_other(owner_q);
  assign own_req   = (owner_q == ARB_OWNER_LDR) ? ldr_req   : cpu_req;
  assign own_lock  = (owner_q == ARB_OWNER_LDR) ? ldr_lock  : cpu_lock;
  assign own_we    = (owner_q == ARB_OWNER_LDR) ? ldr_we    : cpu_we;
  assign own_addr  = (owner_q == ARB_OWNER_LDR) ? ldr_addr  : cpu_addr;
  assign own_wdata = (owner_q == ARB_OWNER_LDR) ? ldr_wdata : cpu_wdata;
  assign oth_req   = (owner_q == ARB_OWNER_LDR) ? cpu_req   : ldr_req;
  assign grant     = (state_q == ARB_OWN) && own_req;

`ifdef ARB_ROUND_ROBIN_EN
  arb_owner_t last_owner_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner_q <= ARB_OWNER_CPU;
    end else if (grant) begin
      last_owner_q <= owner_q;
    end
  end

  always_comb begin
    idle_winner = ARB_OWNER_CPU;
    if (cpu_req && ldr_req) begin
      idle_winner = arb_other(last_owner_q);
    end else if (ldr_req) begin
      idle_winner = ARB_OWNER_LDR;
    end
  end
`else
  assign idle_winner = ldr_req ? ARB_OWNER_LDR : ARB_OWNER_CPU;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= ARB_OWNER_CPU;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    burst_cnt_d = '0;
    case (state_q)
      ARB_IDLE: begin
        if (cpu_req || ldr_req) begin
          state_d = ARB_OWN;
          owner_d = idle_winner;
        end
      end
      ARB_OWN: begin
        // A locked owner keeps the port unless the other side has already waited through the burst limit.
        if (own_req && own_lock && (!oth_req || (burst_cnt_q < BURST_LAST))) begin
          owner_d = owner_q;
        end else if (oth_req) begin
          owner_d = other;
        end else if (own_req) begin
          owner_d = owner_q;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    if ((state_q == ARB_OWN) && (state_d == ARB_OWN) && (owner_d == owner_q)) begin
      burst_cnt_d = (burst_cnt_q == BURST_LAST) ? burst_cnt_q : burst_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    cpu_gnt   = 1'b0;
    ldr_gnt   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant) begin
      mem_en    = 1'b1;
      mem_we    = own_we;
      mem_addr  = own_addr;
      mem_wdata = own_wdata;
      cpu_gnt   = (owner_q == ARB_OWNER_CPU);
      ldr_gnt   = (owner_q == ARB_OWNER_LDR);
    end
  end

  assign rd_tag_in = '{valid: grant && !own_we, owner: owner_q};

  mem_arb_rd_pipe #(
    .MEM_LATENCY (MEM_LATENCY)
  ) u_rd_pipe (
    .clk        (clk),
    .rst        (rst),
    .tag_i      (rd_tag_in),
    .tag_o      (rd_tag_out),
    .inflight_o (rd_inflight)
  );

  assign cpu_rvalid = rd_tag_out.valid && (rd_tag_out.owner == ARB_OWNER_CPU);
  assign ldr_rvalid = rd_tag_out.valid && (rd_tag_out.owner == ARB_OWNER_LDR);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign ldr_rdata  = ldr_rvalid ? mem_rdata : '0;
  assign busy       = (state_q == ARB_OWN) || rd_inflight;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: MEM model with latency, read-return scoreboard, scripted
// grant sequences for ties, starvation limit, interleaved reads and reset mid-read.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int LAT = 2;
  localparam int MB  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, cpu_lock, cpu_gnt, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          ldr_req, ldr_we, ldr_lock, ldr_gnt, ldr_rvalid;
  logic [AW-1:0] ldr_addr;
  logic [DW-1:0] ldr_wdata, ldr_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mem_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MEM_LATENCY(LAT),
    .MAX_BURST  (MB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_lock   (cpu_lock),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .ldr_req    (ldr_req),
    .ldr_we     (ldr_we),
    .ldr_lock   (ldr_lock),
    .ldr_addr   (ldr_addr),
    .ldr_wdata  (ldr_wdata),
    .ldr_gnt    (ldr_gnt),
    .ldr_rvalid (ldr_rvalid),
    .ldr_rdata  (ldr_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // MEM model: synchronous write, read data valid LAT cycles after the enable cycle.
  logic [DW-1:0] mem_model [256];
  logic [DW-1:0] rd_pipe [LAT];

  always @(posedge clk) begin
    if (mem_en && mem_we) mem_model[mem_addr[7:0]] <= mem_wdata;
    rd_pipe[0] <= (mem_en && !mem_we) ? mem_model[mem_addr[7:0]] : 8'hFF;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  // Read scoreboard: expectation pushed when a read is granted, popped when rvalid appears.
  typedef struct {
    arb_owner_t    owner;
    logic [DW-1:0] data;
    int            due;
  } rd_exp_t;

  rd_exp_t exp_q[$];
  rd_exp_t mon_e;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (cpu_rvalid || ldr_rvalid) begin
        if (exp_q.size() == 0) begin
          check("rv_unexpected_qsize", exp_q.size(), 1);
        end else begin
          mon_e = exp_q.pop_front();
          check("rv_both", cpu_rvalid && ldr_rvalid, 0);
          check("rv_owner", ldr_rvalid, mon_e.owner);
          check("rv_data", ldr_rvalid ? ldr_rdata : cpu_rdata, mon_e.data);
          check("rv_other_rdata_zero", ldr_rvalid ? cpu_rdata : ldr_rdata, 0);
          check("rv_cycle", cyc, mon_e.due);
        end
      end else if ((exp_q.size() != 0) && (exp_q[0].due <= cyc)) begin
        check("rv_missing", cpu_rvalid || ldr_rvalid, 1);
        exp_q.delete(0);
      end
      if (cpu_gnt && !cpu_we) exp_q.push_back('{ARB_OWNER_CPU, mem_model[cpu_addr[7:0]], cyc + LAT});
      if (ldr_gnt && !ldr_we) exp_q.push_back('{ARB_OWNER_LDR, mem_model[ldr_addr[7:0]], cyc + LAT});
    end
  end

  arb_owner_t model_last = ARB_OWNER_CPU;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_en"}, mem_en, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_gnts"}, {cpu_gnt, ldr_gnt}, 0);
    check({tag, "_rvalids"}, {cpu_rvalid, ldr_rvalid}, 0);
    check({tag, "_rdatas"}, {cpu_rdata, ldr_rdata}, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // Both request from IDLE; first winner depends on build, the other is granted the next cycle.
  task automatic tie(input logic [7:0] seed);
    arb_owner_t first;
    arb_owner_t second;
`ifdef ARB_ROUND_ROBIN_EN
    first = (model_last == ARB_OWNER_CPU) ? ARB_OWNER_LDR : ARB_OWNER_CPU;
`else
    first = ARB_OWNER_LDR;
`endif
    second    = (first == ARB_OWNER_LDR) ? ARB_OWNER_CPU : ARB_OWNER_LDR;
    cpu_req   = 1'b1; cpu_we = 1'b1; cpu_lock = 1'b0; cpu_addr = 16'h0200; cpu_wdata = seed ^ 8'h22;
    ldr_req   = 1'b1; ldr_we = 1'b1; ldr_lock = 1'b0; ldr_addr = 16'h0100; ldr_wdata = seed ^ 8'h11;
    settle();
    check("tie_idle_no_gnt", {cpu_gnt, ldr_gnt}, 0);
    tick(); settle();
    check("tie1_ldr_gnt", ldr_gnt, first == ARB_OWNER_LDR);
    check("tie1_cpu_gnt", cpu_gnt, first == ARB_OWNER_CPU);
    check("tie1_wdata", mem_wdata, (first == ARB_OWNER_LDR) ? ldr_wdata : cpu_wdata);
    tick();
    if (first == ARB_OWNER_LDR) ldr_req = 1'b0; else cpu_req = 1'b0;
    settle();
    check("tie2_ldr_gnt", ldr_gnt, second == ARB_OWNER_LDR);
    check("tie2_cpu_gnt", cpu_gnt, second == ARB_OWNER_CPU);
    check("tie2_wdata", mem_wdata, (second == ARB_OWNER_LDR) ? ldr_wdata : cpu_wdata);
    tick();
    cpu_req = 1'b0; ldr_req = 1'b0;
    model_last = second;
    settle();
    check("tie_release_no_en", mem_en, 0);
    tick(); settle();
    check("tie_idle_busy", busy, 0);
    tick();
  endtask

  logic [0:8] stv_pat;
  int         idx;

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = 8'h00;
    for (int i = 0; i < LAT; i++) rd_pipe[i] = 8'hFF;
    mem_model[8'h34] = 8'hA5;
    mem_model[8'h10] = 8'h3C;
    mem_model[8'h20] = 8'hC3;

    // Reset: outputs stay 0 even with requests pending.
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_lock = 1'b1; cpu_addr = 16'hBEEF; cpu_wdata = 8'h77;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_lock = 1'b1; ldr_addr = 16'hCAFE; ldr_wdata = 8'h66;
    settle();
    check_all_zero("reset");
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_lock = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_lock = 1'b0; ldr_addr = '0; ldr_wdata = '0;
    rst = 1'b0;
    tick();

    // Single CPU read: grant one cycle after req rises in IDLE, data LAT cycles after grant.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
    settle();
    check("rd_idle_no_gnt", cpu_gnt, 0);
    tick(); settle();
    check("rd_cpu_gnt", cpu_gnt, 1);
    check("rd_ldr_gnt", ldr_gnt, 0);
    check("rd_mem_en", mem_en, 1);
    check("rd_mem_we", mem_we, 0);
    check("rd_mem_addr", mem_addr, 16'h1234);
    check("rd_busy", busy, 1);
    tick();
    cpu_req = 1'b0;
    settle();
    check("rd_release_no_en", mem_en, 0);
    repeat (LAT + 2) tick();
    check("rd_q_empty", exp_q.size(), 0);
    model_last = ARB_OWNER_CPU;

    // Reset while a read is pending: the return is dropped.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
    tick(); settle();
    check("rstrd_cpu_gnt", cpu_gnt, 1);
    tick();
    cpu_req = 1'b0;
    rst = 1'b1;
    settle();
    check_all_zero("rst_mid_read");
    tick(); settle();
    check_all_zero("rst_hold");
    tick();
    rst = 1'b0;
    model_last = ARB_OWNER_CPU;
    for (int k = 0; k < LAT + 2; k++) begin
      settle();
      check("post_rst_no_rvalid", {cpu_rvalid, ldr_rvalid}, 0);
      tick();
    end

    // Ties from IDLE, with a lone loader grant in between to move the round-robin pointer.
    tie(8'h00);
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 16'h0180; ldr_wdata = 8'h5A;
    tick(); settle();
    check("solo_ldr_gnt", ldr_gnt, 1);
    check("solo_ldr_wdata", mem_wdata, 8'h5A);
    tick();
    ldr_req = 1'b0;
    model_last = ARB_OWNER_LDR;
    tick(); tick();
    tie(8'h40);
    tie(8'h80);

    // Starvation limit: locked loader burst yields to a waiting CPU after MAX_BURST grants.
    stv_pat = 9'b111101111;
    idx = 0;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_lock = 1'b1; ldr_addr = 16'h0300; ldr_wdata = 8'h00;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_lock = 1'b0; cpu_addr = 16'h0400; cpu_wdata = 8'hEE;
    for (int k = 0; k < 9; k++) begin
      settle();
      check("stv_ldr_gnt", ldr_gnt, stv_pat[k]);
      check("stv_cpu_gnt", cpu_gnt, !stv_pat[k]);
      check("stv_wdata", mem_wdata, stv_pat[k] ? 8'(idx) : 8'hEE);
      check("stv_addr", mem_addr, stv_pat[k] ? 16'h0300 + 16'(idx) : 16'h0400);
      tick();
      if (stv_pat[k]) begin
        idx++;
        if (idx == 8) begin
          ldr_req = 1'b0; ldr_lock = 1'b0;
        end else begin
          ldr_addr = 16'h0300 + 16'(idx); ldr_wdata = 8'(idx);
        end
      end else begin
        cpu_req = 1'b0;
      end
    end
    settle();
    check("stv_released", mem_en, 0);
    tick(); tick();

    // Interleaved reads: loader then CPU back-to-back, returns on consecutive cycles.
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_lock = 1'b0; ldr_addr = 16'h0010;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_lock = 1'b0; cpu_addr = 16'h0020;
    settle();
    check("il_ldr_gnt", ldr_gnt, 1);
    check("il_ldr_addr", mem_addr, 16'h0010);
    tick();
    ldr_req = 1'b0;
    settle();
    check("il_cpu_gnt", cpu_gnt, 1);
    check("il_cpu_addr", mem_addr, 16'h0020);
    tick();
    cpu_req = 1'b0;
    tick(); settle();
    check("il_busy_read_inflight", busy, 1);
    tick(); settle();
    check("il_busy_clear", busy, 0);
    tick(); tick();
    check("end_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
